// File: rtl/aes_selftest_seq.sv
// Built-in self-test sequencer: walks NUM_VECTORS key/plaintext pairs through the AES core,
// checks each round trip and accumulates an error count and a rotate-XOR ciphertext signature.
module aes_selftest_seq #(
    parameter int unsigned  NUM_VECTORS    = 4,
    parameter int unsigned  TIMEOUT_CYCLES = 1024,
    parameter logic [127:0] BASE_KEY       = 128'h100F0E0D0C0B0A090807060504030201,
    parameter logic [127:0] BASE_PT        = 128'h00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1,
    parameter bit           LOOP           = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    output logic [127:0] core_key,
    output logic [127:0] core_plain,
    output logic         core_start,
    input  logic         core_done,
    input  logic [127:0] core_cipher,
    input  logic [127:0] core_decrypted,
    output logic         busy,
    output logic         pass,
    output logic         fail,
    output logic [7:0]   vec_idx,
    output logic [15:0]  err_count,
    output logic [127:0] signature,
    output logic         timeout_err,
    output logic [2:0]   fsm_state
);

    // Core handshake: core_start is a one-cycle request issued from ISSUE; the core answers
    // with a core_done pulse carrying core_cipher/core_decrypted, which is only honoured in WAIT.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_CHECK = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int unsigned TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_VECTORS - 1);

    state_t         state;
    logic [TW-1:0]  tmo_cnt;
    logic [127:0]   cipher_q;
    logic [127:0]   dec_q;
    logic           timed_out;
    logic           vec_failed;
    logic [15:0]    err_next;

    assign fsm_state = state;

    always_comb begin
        vec_failed = timed_out || (dec_q != core_plain) || (cipher_q == core_plain);
        err_next   = err_count;
        if (vec_failed && (err_count != 16'hFFFF)) begin
            err_next = err_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            core_key    <= '0;
            core_plain  <= '0;
            core_start  <= 1'b0;
            busy        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            vec_idx     <= '0;
            err_count   <= '0;
            signature   <= '0;
            timeout_err <= 1'b0;
            tmo_cnt     <= '0;
            cipher_q    <= '0;
            dec_q       <= '0;
            timed_out   <= 1'b0;
        end else begin
            core_start <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    // A LOOP restart keeps err_count/timeout_err; only an explicit start clears them.
                    if (start || ((state == S_DONE) && LOOP)) begin
                        vec_idx   <= '0;
                        signature <= '0;
                        busy      <= 1'b1;
                        pass      <= 1'b0;
                        fail      <= 1'b0;
                        state     <= S_LOAD;
                        if (start) begin
                            err_count   <= '0;
                            timeout_err <= 1'b0;
                        end
                    end
                end
                S_LOAD: begin
                    core_key   <= BASE_KEY + {120'b0, vec_idx};
                    core_plain <= BASE_PT ^ {120'b0, vec_idx};
                    core_start <= 1'b1;
                    state      <= S_ISSUE;
                end
                S_ISSUE: begin
                    tmo_cnt   <= '0;
                    timed_out <= 1'b0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    if (core_done) begin
                        cipher_q <= core_cipher;
                        dec_q    <= core_decrypted;
                        state    <= S_CHECK;
                    end else if (tmo_cnt == TMO_LAST) begin
                        // A timed-out vector contributes zero to the signature.
                        cipher_q    <= '0;
                        timed_out   <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= S_CHECK;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                S_CHECK: begin
                    err_count <= err_next;
                    signature <= {signature[126:0], signature[127]} ^ cipher_q;
                    if (vec_idx == LAST_IDX) begin
                        busy  <= 1'b0;
                        pass  <= (err_next == 16'd0);
                        fail  <= (err_next != 16'd0);
                        state <= S_DONE;
                    end else begin
                        vec_idx <= vec_idx + 8'd1;
                        state   <= S_LOAD;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_selftest_seq.sv
// Bench for aes_selftest_seq: two instances (single pass and LOOP) driven by a behavioural
// AES core stand-in, with a key/plaintext scoreboard and model-computed signatures.
module tb_aes_selftest_seq;

    localparam logic [127:0] BASE_KEY = 128'h100F0E0D0C0B0A090807060504030201;
    localparam logic [127:0] BASE_PT  = 128'h00FFFEFDFCFBFAF9F8F7F6F5F4F3F2F1;
    localparam int NV  = 4;
    localparam int TMO = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic start_s [2];
    logic stray   [2];
    int   wlat    [2];
    int   drop_v  [2];
    int   flip_v  [2];
    bit   ceq     [2];

    logic [127:0] core_key_s [2];
    logic [127:0] core_plain_s [2];
    logic [127:0] signature_s [2];
    logic         core_start_s [2];
    logic         busy_s [2];
    logic         pass_s [2];
    logic         fail_s [2];
    logic         timeout_err_s [2];
    logic [7:0]   vec_idx_s [2];
    logic [15:0]  err_count_s [2];
    logic [2:0]   fsm_state_s [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int starts [2] = '{0, 0};
    int st_cyc0 [$];
    logic [263:0] exp_q [$];

    function automatic logic [127:0] gen_key(input int i);
        return BASE_KEY + 128'(i);
    endfunction

    function automatic logic [127:0] gen_pt(input int i);
        return BASE_PT ^ {120'b0, i[7:0]};
    endfunction

    function automatic logic [127:0] exp_sig(input bit eq, input int drop);
        logic [127:0] s = '0;
        logic [127:0] c;
        for (int i = 0; i < NV; i++) begin
            c = (i == drop) ? 128'd0 : (eq ? gen_pt(i) : ~gen_pt(i));
            s = {s[126:0], s[127]} ^ c;
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // DUT instances and a behavioural core answering each core_start after wlat edges.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic         m_done;
        logic         core_done;
        logic [127:0] cipher;
        logic [127:0] dec;
        logic [127:0] pl;
        int           cd;
        int           nst;
        int           idx;

        assign core_done = m_done | stray[g];

        aes_selftest_seq #(
            .NUM_VECTORS(NV), .TIMEOUT_CYCLES(TMO),
            .BASE_KEY(BASE_KEY), .BASE_PT(BASE_PT), .LOOP(g == 1)
        ) u_dut (
            .clk(clk), .rst(rst), .start(start_s[g]),
            .core_key(core_key_s[g]), .core_plain(core_plain_s[g]),
            .core_start(core_start_s[g]), .core_done(core_done),
            .core_cipher(cipher), .core_decrypted(dec),
            .busy(busy_s[g]), .pass(pass_s[g]), .fail(fail_s[g]),
            .vec_idx(vec_idx_s[g]), .err_count(err_count_s[g]),
            .signature(signature_s[g]), .timeout_err(timeout_err_s[g]),
            .fsm_state(fsm_state_s[g])
        );

        always @(posedge clk) begin : model
            logic         fire;
            logic [127:0] fp;
            int           fix;
            if (rst) begin
                m_done <= 1'b0;
                cd     <= 0;
                nst    <= 0;
                idx    <= 0;
                pl     <= '0;
                cipher <= '0;
                dec    <= '0;
            end else begin
                fire = 1'b0;
                fp   = pl;
                fix  = idx;
                m_done <= 1'b0;
                if (core_start_s[g]) begin
                    pl  <= core_plain_s[g];
                    idx <= nst % NV;
                    nst <= nst + 1;
                    if (wlat[g] == 0) begin
                        fire = 1'b1;
                        fp   = core_plain_s[g];
                        fix  = nst % NV;
                    end else begin
                        cd <= wlat[g];
                    end
                end else if (cd > 0) begin
                    cd  <= cd - 1;
                    fire = (cd == 1);
                end
                if (fire) begin
                    m_done <= (fix != drop_v[g]);
                    cipher <= ceq[g] ? fp : ~fp;
                    dec    <= fp ^ ((fix == flip_v[g]) ? 128'd1 : 128'd0);
                end
            end
        end
    end

    // Scoreboard for instance 0: every core_start pops one expected {idx, key, plain}.
    always @(negedge clk) begin : mon0
        logic [263:0] e;
        if (!rst && core_start_s[0]) begin
            starts[0]++;
            st_cyc0.push_back(cyc);
            chk("sb_nonempty", 128'(exp_q.size() != 0), 128'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_idx", 128'(vec_idx_s[0]), 128'(e[263:256]));
                chk("sb_key", core_key_s[0], e[255:128]);
                chk("sb_pt", core_plain_s[0], e[127:0]);
            end
        end
        cyc++;
    end

    // Instance 1 loops forever, so its expected vector is derived from the start count.
    always @(negedge clk) begin : mon1
        if (!rst && core_start_s[1]) begin
            chk("lp_key", core_key_s[1], gen_key(starts[1] % NV));
            chk("lp_pt", core_plain_s[1], gen_pt(starts[1] % NV));
            starts[1]++;
        end
    end

    task automatic push_vectors();
        for (int i = 0; i < NV; i++) exp_q.push_back({8'(i), gen_key(i), gen_pt(i)});
    endtask

    task automatic pulse_start(input int g);
        start_s[g] = 1'b1;
        @(negedge clk);
        start_s[g] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_end(input int g);
        int n = 0;
        while (!(pass_s[g] || fail_s[g]) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("done_reached", 128'(pass_s[g] || fail_s[g]), 128'd1);
    endtask

    initial begin
        int base;
        int c0;
        int n;
        start_s = '{1'b0, 1'b0};
        stray   = '{1'b0, 1'b0};
        wlat    = '{9, 9};
        drop_v  = '{-1, -1};
        flip_v  = '{-1, -1};
        ceq     = '{1'b0, 1'b0};

        // Reset held for three cycles; every output must be zero.
        repeat (3) @(negedge clk);
        chk("rst_busy", 128'(busy_s[0]), 128'd0);
        chk("rst_pass", 128'(pass_s[0]), 128'd0);
        chk("rst_fail", 128'(fail_s[0]), 128'd0);
        chk("rst_vec_idx", 128'(vec_idx_s[0]), 128'd0);
        chk("rst_err", 128'(err_count_s[0]), 128'd0);
        chk("rst_sig", signature_s[0], 128'd0);
        chk("rst_tmo", 128'(timeout_err_s[0]), 128'd0);
        chk("rst_key", core_key_s[0], 128'd0);
        chk("rst_plain", core_plain_s[0], 128'd0);
        chk("rst_core_start", 128'(core_start_s[0]), 128'd0);
        rst = 1'b0;

        // Directed 1: ideal core.
        push_vectors();
        base = starts[0];
        c0 = st_cyc0.size();
        @(negedge clk);
        pulse_start(0);
        wait_end(0);
        chk("d1_starts", 128'(starts[0] - base), 128'd4);
        chk("d1_pass", 128'(pass_s[0]), 128'd1);
        chk("d1_fail", 128'(fail_s[0]), 128'd0);
        chk("d1_busy", 128'(busy_s[0]), 128'd0);
        chk("d1_err", 128'(err_count_s[0]), 128'd0);
        chk("d1_tmo", 128'(timeout_err_s[0]), 128'd0);
        chk("d1_sig", signature_s[0], exp_sig(1'b0, -1));
        chk("d1_key3", core_key_s[0], 128'h100F0E0D0C0B0A090807060504030204);
        chk("d1_gap", 128'(st_cyc0[c0 + 1] - st_cyc0[c0]), 128'd13);
        chk("d1_q_empty", 128'(exp_q.size()), 128'd0);

        // Directed 2: decrypted bit 0 flipped on vector 2; restarted straight from DONE.
        flip_v[0] = 2;
        push_vectors();
        base = starts[0];
        @(negedge clk);
        pulse_start(0);
        wait_end(0);
        chk("d2_starts", 128'(starts[0] - base), 128'd4);
        chk("d2_err", 128'(err_count_s[0]), 128'd1);
        chk("d2_fail", 128'(fail_s[0]), 128'd1);
        chk("d2_pass", 128'(pass_s[0]), 128'd0);
        chk("d2_sig", signature_s[0], exp_sig(1'b0, -1));

        // Directed 3: vector 1 never completes.
        flip_v[0] = -1;
        drop_v[0] = 1;
        push_vectors();
        base = starts[0];
        c0 = st_cyc0.size();
        @(negedge clk);
        pulse_start(0);
        wait_end(0);
        chk("d3_starts", 128'(starts[0] - base), 128'd4);
        chk("d3_tmo_gap", 128'(st_cyc0[c0 + 2] - st_cyc0[c0 + 1]), 128'd19);
        chk("d3_tmo", 128'(timeout_err_s[0]), 128'd1);
        chk("d3_err", 128'(err_count_s[0]), 128'd1);
        chk("d3_fail", 128'(fail_s[0]), 128'd1);
        chk("d3_vec_idx", 128'(vec_idx_s[0]), 128'd3);
        chk("d3_sig", signature_s[0], exp_sig(1'b0, 1));

        // Directed 4: reset in WAIT of vector 2, then a fresh run with stray starts.
        drop_v[0] = -1;
        do_reset();
        push_vectors();
        base = starts[0];
        pulse_start(0);
        n = 0;
        while ((starts[0] - base) < 3 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("d4_reach_v2", 128'(starts[0] - base), 128'd3);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("d4_busy", 128'(busy_s[0]), 128'd0);
        chk("d4_vec_idx", 128'(vec_idx_s[0]), 128'd0);
        chk("d4_key", core_key_s[0], 128'd0);
        chk("d4_plain", core_plain_s[0], 128'd0);
        chk("d4_core_start", 128'(core_start_s[0]), 128'd0);
        chk("d4_pass_fail", 128'({pass_s[0], fail_s[0]}), 128'd0);
        repeat (20) @(negedge clk);
        chk("d4_no_more_starts", 128'(starts[0] - base), 128'd3);
        exp_q.delete();
        push_vectors();
        base = starts[0];
        pulse_start(0);
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(2, 4)) @(negedge clk);
            pulse_start(0);
        end
        wait_end(0);
        chk("d4_run_starts", 128'(starts[0] - base), 128'd4);
        chk("d4_run_pass", 128'(pass_s[0]), 128'd1);
        chk("d4_run_sig", signature_s[0], exp_sig(1'b0, -1));

        // Directed 6: stray done in LOAD/ISSUE, zero-latency core.
        do_reset();
        wlat[0] = 0;
        push_vectors();
        base = starts[0];
        start_s[0] = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            start_s[0] = 1'b0;
            stray[0] = (k <= 16) && (((k - 1) % 4) < 2);
            if (k == 16) chk("d6_busy_16", 128'(busy_s[0]), 128'd1);
            if (k == 17) chk("d6_pass_17", 128'(pass_s[0]), 128'd1);
        end
        stray[0] = 1'b0;
        chk("d6_starts", 128'(starts[0] - base), 128'd4);
        chk("d6_err", 128'(err_count_s[0]), 128'd0);
        chk("d6_sig", signature_s[0], exp_sig(1'b0, -1));

        // Directed 5: LOOP instance with cipher == plain on every vector.
        ceq[1] = 1'b1;
        base = starts[1];
        pulse_start(1);
        wait_end(1);
        chk("d5_p1_fail", 128'(fail_s[1]), 128'd1);
        chk("d5_p1_err", 128'(err_count_s[1]), 128'd4);
        chk("d5_p1_sig", signature_s[1], exp_sig(1'b1, -1));
        chk("d5_p1_starts", 128'(starts[1] - base), 128'd4);
        @(negedge clk);
        chk("d5_restart_sig", signature_s[1], 128'd0);
        chk("d5_restart_idx", 128'(vec_idx_s[1]), 128'd0);
        chk("d5_restart_busy", 128'(busy_s[1]), 128'd1);
        @(negedge clk);
        chk("d5_resume_start", 128'(core_start_s[1]), 128'd1);
        wait_end(1);
        chk("d5_p2_err", 128'(err_count_s[1]), 128'd8);
        chk("d5_p2_sig", signature_s[1], exp_sig(1'b1, -1));
        chk("d5_p2_starts", 128'(starts[1] - base), 128'd8);
        chk("d5_p2_tmo", 128'(timeout_err_s[1]), 128'd0);

        rst = 1'b1;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
